// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit front end.
//   BYTE_W         : width of one transmitted byte
//   feeder_state_e : feeder FSM states (IDLE / SEND / GAP)
//   level_width()  : width of a 0..depth occupancy count
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } feeder_state_e;

    // One extra bit so that a completely full FIFO (level == depth) is representable.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with synchronous clear; writes are never bypassed to the read port.
// Ports:
//   CLK_I, RST_I : clock, synchronous active-high reset
//   CLEAR_I      : flush contents (a concurrent push is discarded)
//   push, push_data : enqueue request; accepted only while ready is high
//   pop, pop_data_c : dequeue request; pop_data_c is the current head (combinational)
//   ready        : registered !full
//   empty        : registered level == 0
//   level        : registered number of stored bytes
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned LVL_W = level_width(DEPTH)
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              CLEAR_I,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] pop_data_c,
    output logic              ready,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_d;
    logic              push_ok_c;
    logic              pop_ok_c;

    // Acceptance is decided from registered flags only, so a pop never frees room for a same-cycle push.
    assign push_ok_c = push && ready && !CLEAR_I;
    assign pop_ok_c  = pop && !empty;

    // Next occupancy
    always_comb begin
        level_d = level;
        if (CLEAR_I) begin
            level_d = '0;
        end else if (push_ok_c && !pop_ok_c) begin
            level_d = level + LVL_W'(1);
        end else if (!push_ok_c && pop_ok_c) begin
            level_d = level - LVL_W'(1);
        end
    end

    // Pointers and registered status flags
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b1;
            empty  <= 1'b1;
        end else begin
            level <= level_d;
            ready <= (level_d != LVL_W'(DEPTH));
            empty <= (level_d == '0);
            if (CLEAR_I) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage array (no reset needed: only written entries are ever read)
    always_ff @(posedge CLK_I) begin
        if (push_ok_c) mem[wr_ptr] <= push_data;
    end

    assign pop_data_c = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer in front of the UART transmitter: queues bytes from the debug transport and
// hands them to the transmitter one frame at a time, with an optional idle gap between frames.
// Ports:
//   CLK_I, RST_I        : clock, synchronous active-high reset
//   DATA_I, VALID_I     : byte to enqueue / valid; READY_O is !full
//   CLEAR_I             : flush queued bytes (the in-flight frame is unaffected)
//   CHANNEL_I           : TX line owned by the secondary channel; blocks starts, aborts a frame in flight
//   TX_START_O, TX_DATA_O, TX_DONE_I : transmitter handshake
//   BUSY_O              : frame in flight, start pending, or gap running
//   LEVEL_O             : number of queued bytes
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH      = 16,
    parameter  int unsigned GAP_CYCLES = 0,
    localparam int unsigned LVL_W      = level_width(DEPTH)
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [BYTE_W-1:0] DATA_I,
    input  logic              VALID_I,
    output logic              READY_O,
    input  logic              CLEAR_I,
    input  logic              CHANNEL_I,
    output logic              TX_START_O,
    output logic [BYTE_W-1:0] TX_DATA_O,
    input  logic              TX_DONE_I,
    output logic              BUSY_O,
    output logic [LVL_W-1:0]  LEVEL_O
);

    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    feeder_state_e     state;
    logic [GAP_W-1:0]  gap_cnt;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_data_c;
    logic              pop_c;

    // A byte leaves the queue only from IDLE, with data present and the line ours.
    assign pop_c = (state == ST_IDLE) && !fifo_empty && !CHANNEL_I;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .CLEAR_I    (CLEAR_I),
        .push       (VALID_I),
        .push_data  (DATA_I),
        .pop        (pop_c),
        .pop_data_c (fifo_data_c),
        .ready      (READY_O),
        .empty      (fifo_empty),
        .level      (LEVEL_O)
    );

    // Feeder FSM, gap counter and registered handshake outputs
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            TX_START_O <= 1'b0;
            TX_DATA_O  <= '0;
            BUSY_O     <= 1'b0;
        end else begin
            TX_START_O <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        TX_DATA_O  <= fifo_data_c;
                        TX_START_O <= 1'b1;
                        BUSY_O     <= 1'b1;
                        state      <= ST_SEND;
                    end else begin
                        BUSY_O <= 1'b0;
                    end
                end
                ST_SEND: begin
                    // Losing the line silences the transmitter, so no done will come: drop the frame.
                    if (CHANNEL_I) begin
                        BUSY_O <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (TX_DONE_I) begin
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= GAP_W'(GAP_LOAD);
                            BUSY_O  <= 1'b1;
                            state   <= ST_GAP;
                        end else begin
                            BUSY_O <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end else begin
                        BUSY_O <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        BUSY_O <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                        BUSY_O  <= 1'b1;
                    end
                end
                default: begin
                    BUSY_O <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: two instances (DEPTH=4/GAP=3 and DEPTH=16/GAP=0) share the
// byte-side inputs; a queue-based model predicts every output each cycle, directed
// sequences pin the model with literal expectations, then a randomized phase runs.
module tb_uart_tx_feeder;

    localparam int NI = 2;

    function automatic int dep_of(input int k);
        return (k == 0) ? 4 : 16;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    logic          CLK_I     = 1'b0;
    logic          RST_I     = 1'b1;
    logic          VALID_I   = 1'b0;
    logic          CLEAR_I   = 1'b0;
    logic          CHANNEL_I = 1'b0;
    logic [7:0]    DATA_I    = 8'h00;
    logic [NI-1:0] TX_DONE_I = '0;
    logic [NI-1:0] READY_O;
    logic [NI-1:0] TX_START_O;
    logic [NI-1:0] BUSY_O;
    logic [7:0]    data_a;
    logic [7:0]    data_b;
    logic [2:0]    level_a;
    logic [4:0]    level_b;

    always #5 CLK_I = ~CLK_I;

    uart_tx_feeder #(.DEPTH(4), .GAP_CYCLES(3)) u_dut_a (
        .CLK_I(CLK_I), .RST_I(RST_I), .DATA_I(DATA_I), .VALID_I(VALID_I), .READY_O(READY_O[0]),
        .CLEAR_I(CLEAR_I), .CHANNEL_I(CHANNEL_I), .TX_START_O(TX_START_O[0]), .TX_DATA_O(data_a),
        .TX_DONE_I(TX_DONE_I[0]), .BUSY_O(BUSY_O[0]), .LEVEL_O(level_a)
    );

    uart_tx_feeder #(.DEPTH(16), .GAP_CYCLES(0)) u_dut_b (
        .CLK_I(CLK_I), .RST_I(RST_I), .DATA_I(DATA_I), .VALID_I(VALID_I), .READY_O(READY_O[1]),
        .CLEAR_I(CLEAR_I), .CHANNEL_I(CHANNEL_I), .TX_START_O(TX_START_O[1]), .TX_DATA_O(data_b),
        .TX_DONE_I(TX_DONE_I[1]), .BUSY_O(BUSY_O[1]), .LEVEL_O(level_b)
    );

    // ---------------- behavioural model ----------------
    // Queue of waiting bytes; phase 0 = idle, 1 = frame on the wire, 2 = gap with gap_left cycles to go.
    logic [7:0] mbuf [NI][64];
    int         mhead [NI];
    int         mcnt [NI];
    int         mphase [NI];
    int         gap_left [NI];
    logic       e_start [NI];
    logic       e_busy [NI];
    logic [7:0] e_data [NI];
    logic       m_on = 1'b0;

    always @(posedge CLK_I) begin
        for (int k = 0; k < NI; k++) begin
            if (RST_I) begin
                m_on        = 1'b1;
                mhead[k]    = 0;
                mcnt[k]     = 0;
                mphase[k]   = 0;
                gap_left[k] = 0;
                e_start[k]  = 1'b0;
                e_busy[k]   = 1'b0;
                e_data[k]   = 8'h00;
            end else begin
                bit accept;
                accept = VALID_I && !CLEAR_I && (mcnt[k] < dep_of(k));
                e_start[k] = 1'b0;
                if (mphase[k] == 0) begin
                    if (mcnt[k] > 0 && !CHANNEL_I) begin
                        e_data[k]  = mbuf[k][mhead[k] % 64];
                        mhead[k]   = mhead[k] + 1;
                        mcnt[k]    = mcnt[k] - 1;
                        e_start[k] = 1'b1;
                        mphase[k]  = 1;
                    end
                end else if (mphase[k] == 1) begin
                    if (CHANNEL_I) mphase[k] = 0;
                    else if (TX_DONE_I[k]) begin
                        gap_left[k] = gap_of(k);
                        mphase[k]   = (gap_of(k) > 0) ? 2 : 0;
                    end
                end else begin
                    gap_left[k] = gap_left[k] - 1;
                    if (gap_left[k] == 0) mphase[k] = 0;
                end
                if (CLEAR_I) mcnt[k] = 0;
                else if (accept) begin
                    mbuf[k][(mhead[k] + mcnt[k]) % 64] = DATA_I;
                    mcnt[k] = mcnt[k] + 1;
                end
                e_busy[k] = (mphase[k] != 0) || e_start[k];
            end
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_cmp();
        chk("a_start", 32'(TX_START_O[0]), 32'(e_start[0]));
        chk("a_data",  32'(data_a),        32'(e_data[0]));
        chk("a_busy",  32'(BUSY_O[0]),     32'(e_busy[0]));
        chk("a_level", 32'(level_a),       32'(mcnt[0]));
        chk("a_ready", 32'(READY_O[0]),    32'(mcnt[0] < dep_of(0)));
        chk("b_start", 32'(TX_START_O[1]), 32'(e_start[1]));
        chk("b_data",  32'(data_b),        32'(e_data[1]));
        chk("b_busy",  32'(BUSY_O[1]),     32'(e_busy[1]));
        chk("b_level", 32'(level_b),       32'(mcnt[1]));
        chk("b_ready", 32'(READY_O[1]),    32'(mcnt[1] < dep_of(1)));
    endtask

    // ---------------- transmitter emulation and cycle stepping ----------------
    int tx_left [NI];
    bit auto_tx [NI];
    bit stray_en = 1'b0;

    // Advance one cycle: inputs set before the call are sampled by the coming rising edge.
    task automatic step();
        @(negedge CLK_I);
        VALID_I = 1'b0;
        CLEAR_I = 1'b0;
        if (m_on) model_cmp();
        for (int k = 0; k < NI; k++) begin
            TX_DONE_I[k] = 1'b0;
            if (auto_tx[k]) begin
                if (RST_I || CHANNEL_I) tx_left[k] = 0;
                else if (TX_START_O[k]) tx_left[k] = int'($urandom_range(1, 4));
                else if (tx_left[k] > 0) begin
                    tx_left[k] = tx_left[k] - 1;
                    if (tx_left[k] == 0) TX_DONE_I[k] = 1'b1;
                end else if (stray_en && $urandom_range(0, 24) == 0) TX_DONE_I[k] = 1'b1;
            end
        end
    endtask

    task automatic push(input logic [7:0] d);
        VALID_I = 1'b1;
        DATA_I  = d;
        step();
    endtask

    // Steps until instance A shows a start (bounded); returns the number of steps taken.
    task automatic wait_start_a(input string nm, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!TX_START_O[0] && n < 40);
        chk(nm, 32'(TX_START_O[0]), 32'd1);
    endtask

    task automatic chk_reset_a(input string nm);
        chk({nm, "_start"}, 32'(TX_START_O[0]), 32'd0);
        chk({nm, "_data"},  32'(data_a),        32'h00);
        chk({nm, "_busy"},  32'(BUSY_O[0]),     32'd0);
        chk({nm, "_level"}, 32'(level_a),       32'd0);
        chk({nm, "_ready"}, 32'(READY_O[0]),    32'd1);
    endtask

    initial begin
        int n;
        auto_tx[0] = 1'b0;
        auto_tx[1] = 1'b1;
        tx_left[0] = 0;
        tx_left[1] = 0;

        // Reset values
        RST_I = 1'b1;
        step();
        step();
        chk_reset_a("rst");
        chk("rst_b_level", 32'(level_b), 32'd0);
        RST_I = 1'b0;

        // Single byte: start two cycles after the push, data held until done
        push(8'hA5);
        chk("t1_start_n1", 32'(TX_START_O[0]), 32'd0);
        chk("t1_level_n1", 32'(level_a), 32'd1);
        step();
        chk("t1_start_n2", 32'(TX_START_O[0]), 32'd1);
        chk("t1_data", 32'(data_a), 32'hA5);
        chk("t1_level_n2", 32'(level_a), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_hold_data", 32'(data_a), 32'hA5);
            chk("t1_one_pulse", 32'(TX_START_O[0]), 32'd0);
        end
        TX_DONE_I[0] = 1'b1;
        step();
        chk("t1_busy_gap", 32'(BUSY_O[0]), 32'd1);
        repeat (4) step();
        chk("t1_busy_end", 32'(BUSY_O[0]), 32'd0);

        // Fill DEPTH=4 while the line is held, fifth byte refused, then drain in order
        CHANNEL_I = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push(8'(i));
            if (i == 4) chk("t2_ready_full", 32'(READY_O[0]), 32'd0);
        end
        chk("t2_level_full", 32'(level_a), 32'd4);
        CHANNEL_I = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wait_start_a("t2_start", n);
            chk("t2_spacing", 32'(n), (i == 1) ? 32'd1 : 32'd5);
            chk("t2_order", 32'(data_a), 32'(i));
            if (i == 1) chk("t2_ready_again", 32'(READY_O[0]), 32'd1);
            step();
            step();
            TX_DONE_I[0] = 1'b1;
        end
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t2_no_extra", 32'(TX_START_O[0]), 32'd0);
        end

        // Channel blocks starts, then aborts a frame in flight (byte lost, queue untouched)
        CHANNEL_I = 1'b1;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_blocked", 32'(TX_START_O[0]), 32'd0);
        end
        chk("t3_level", 32'(level_a), 32'd3);
        CHANNEL_I = 1'b0;
        wait_start_a("t3_start1", n);
        chk("t3_data1", 32'(data_a), 32'h31);
        step();
        CHANNEL_I = 1'b1;
        step();
        chk("t3_abort_busy", 32'(BUSY_O[0]), 32'd0);
        chk("t3_abort_level", 32'(level_a), 32'd2);
        repeat (3) step();
        CHANNEL_I = 1'b0;
        wait_start_a("t3_start2", n);
        chk("t3_resume_lat", 32'(n), 32'd1);
        chk("t3_data2", 32'(data_a), 32'h32);
        step();
        TX_DONE_I[0] = 1'b1;
        wait_start_a("t3_start3", n);
        chk("t3_data3", 32'(data_a), 32'h33);
        step();
        TX_DONE_I[0] = 1'b1;
        repeat (6) step();

        // Simultaneous push and pop at level 2, then clear during a frame
        CHANNEL_I = 1'b1;
        push(8'h41);
        push(8'h42);
        chk("t4_level2", 32'(level_a), 32'd2);
        CHANNEL_I = 1'b0;
        push(8'h43);
        chk("t4_level_same", 32'(level_a), 32'd2);
        chk("t4_start", 32'(TX_START_O[0]), 32'd1);
        chk("t4_data", 32'(data_a), 32'h41);
        step();
        CLEAR_I = 1'b1;
        push(8'h44);
        chk("t4_clear_level", 32'(level_a), 32'd0);
        chk("t4_clear_busy", 32'(BUSY_O[0]), 32'd1);
        step();
        TX_DONE_I[0] = 1'b1;
        step();
        chk("t4_gap_busy", 32'(BUSY_O[0]), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_no_start", 32'(TX_START_O[0]), 32'd0);
        end
        chk("t4_idle", 32'(BUSY_O[0]), 32'd0);

        // Reset mid-frame; a late done is ignored
        CHANNEL_I = 1'b1;
        push(8'h51);
        push(8'h52);
        push(8'h53);
        CHANNEL_I = 1'b0;
        wait_start_a("t5_start", n);
        chk("t5_data", 32'(data_a), 32'h51);
        chk("t5_level", 32'(level_a), 32'd2);
        step();
        RST_I = 1'b1;
        step();
        chk_reset_a("t5_rst");
        RST_I = 1'b0;
        TX_DONE_I[0] = 1'b1;
        step();
        chk("t5_late_done_busy", 32'(BUSY_O[0]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_no_start", 32'(TX_START_O[0]), 32'd0);
        end

        // Randomized traffic against the model
        auto_tx[0] = 1'b1;
        stray_en   = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            VALID_I = ($urandom_range(0, 99) < (((c / 500) % 2 == 0) ? 70 : 20));
            DATA_I  = 8'($urandom);
            CLEAR_I = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 59) == 0) CHANNEL_I = ~CHANNEL_I;
            RST_I   = ($urandom_range(0, 499) == 0);
            step();
        end
        RST_I     = 1'b0;
        CHANNEL_I = 1'b0;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
